dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single CPU-side port of the data memory (t_dpram_sclk_be port A) between the processor data
//  path and a DMA/boot requester. Grants one access per cycle, tracks 1-cycle synchronous read latency,
//  routes read data back to the owner and produces the CPU stall. Sits between data_mem translators and the RAM.
// PARAMETERS
//  AW            6   word-address width of the memory (64 words)
//  DW            32  data width; byte enables are DW/8 = 4 bits
//  STARVE_LIMIT  4   consecutive denied DMA cycles before DMA is forced priority (legal 1..255)
// PORTS
//  clk          in   1      clock; all state on rising edge
//  reset        in   1      synchronous, active-high reset
//  cpu_req      in   1      CPU access request; held with fields stable until cpu_stalled is low
//  cpu_we       in   1      1 = store, 0 = load
//  cpu_addr     in   AW     CPU word address
//  cpu_be       in   4      CPU byte enables (from store translator; ignored on load)
//  cpu_wdata    in   DW     CPU store data, already lane-aligned
//  cpu_stalled  out  1      CPU must hold its request this cycle
//  cpu_rdata    out  DW     load data, valid when cpu_rvalid
//  cpu_rvalid   out  1      1-cycle pulse: cpu_rdata valid
//  dma_req      in   1      DMA request; held stable until dma_gnt
//  dma_we       in   1      1 = write full word, 0 = read
//  dma_addr     in   AW     DMA word address
//  dma_wdata    in   DW     DMA write data
//  dma_gnt      out  1      DMA access issued this cycle (combinational)
//  dma_rdata    out  DW     read data, valid when dma_rvalid
//  dma_rvalid   out  1      1-cycle pulse: dma_rdata valid
//  mem_we       out  1      RAM write enable
//  mem_be       out  4      RAM byte enables (4'hf on any DMA access)
//  mem_addr     out  AW     RAM address
//  mem_wdata    out  DW     RAM write data
//  mem_rdata    in   DW     RAM read data, registered by RAM, valid cycle after address
// BEHAVIOUR
//  - CPU FSM: C_IDLE, C_RESP. C_IDLE->C_RESP when a CPU load is granted; C_RESP->C_IDLE unconditionally.
//  - cpu_eligible = cpu_req & (state==C_IDLE). In C_RESP the held CPU request is already served: not re-issued.
//  - Arbitration per cycle: if starve_cnt==STARVE_LIMIT and dma_req -> DMA; else if cpu_eligible -> CPU;
//    else if dma_req -> DMA; else none (mem_we=0, mem_addr/mem_wdata/mem_be = CPU fields, don't-care).
//  - starve_cnt: +1 each cycle dma_req & ~dma_gnt (saturate at STARVE_LIMIT); cleared on dma_gnt or ~dma_req.
//  - Winner drives mem_*; mem_we = winner's we (CPU store additionally needs cpu_be; DMA uses 4'hf).
//  - cpu_stalled = cpu_req & ( (state==C_IDLE & ~cpu_gnt) | (state==C_IDLE & cpu_gnt & ~cpu_we) ).
//    Store granted: no stall (0 latency). Load granted: stall 1 cycle; released in C_RESP.
//  - Read return: 1-bit rd_owner + rd_pend registered at grant of a read; next cycle the owner's rvalid=1 and
//    its rdata = mem_rdata. cpu_rvalid == (state==C_RESP). Both rdata outputs mirror mem_rdata continuously.
//  - Back-to-back: DMA may be granted in C_RESP cycle (CPU ineligible); DMA reads may issue every cycle.
//  - Simultaneous CPU & DMA with starve_cnt<LIMIT: CPU wins; DMA denied, counter increments.
//  - Reset (sync, any cycle): state=C_IDLE, starve_cnt=0, rd_pend=0; outputs after reset: cpu_rvalid=0,
//    dma_rvalid=0; dma_gnt/cpu_stalled/mem_we follow inputs combinationally but mem_we forced 0 while reset=1.
//    A read granted in the reset cycle returns no rvalid.
//  - No X propagation: all registers have reset values; unknown cpu_req during reset has no effect.
// TESTING
//  1. Reset then CPU load addr 5 (RAM[5]=32'hDEADBEEF), no DMA -> cpu_stalled=1 cyc0, cpu_rvalid=1 &
//     cpu_rdata=DEADBEEF cyc1, cpu_stalled=0 cyc1, single RAM read.
//  2. CPU store addr 3 be=4'b0100 data 32'h00AB0000 -> mem_we=1 same cycle, no stall; readback byte2=AB only.
//  3. CPU & DMA read both requesting every cycle, STARVE_LIMIT=4 -> DMA granted in C_RESP cycles or
//     at latest after 4 denied cycles; dma_rvalid exactly 1 cycle after each dma_gnt.
//  4. CPU stores back-to-back 6 cycles, DMA write pending -> dma_gnt on 5th cycle, cpu_stalled=1 that cycle,
//     starve_cnt back to 0 after.
//  5. Assert reset in cycle of a granted CPU load -> cpu_rvalid=0 next cycle, state C_IDLE, load re-issued.
//  6. DMA writes words 0..63 with data=addr then CPU loads all -> every cpu_rdata equals address.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares RAM port A between CPU and DMA.
// One access per cycle, 1-cycle read return, CPU stall, DMA anti-starvation.
module dmem_port_arbiter #(
   parameter int AW           = 6,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [AW-1:0]     i_cpu_addr,
   input  logic [DW/8-1:0]   i_cpu_be,
   input  logic [DW-1:0]     i_cpu_wdata,
   output logic              o_cpu_stalled,
   output logic [DW-1:0]     o_cpu_rdata,
   output logic              o_cpu_rvalid,
   input  logic              i_dma_req,
   input  logic              i_dma_we,
   input  logic [AW-1:0]     i_dma_addr,
   input  logic [DW-1:0]     i_dma_wdata,
   output logic              o_dma_gnt,
   output logic [DW-1:0]     o_dma_rdata,
   output logic              o_dma_rvalid,
   output logic              o_mem_we,
   output logic [DW/8-1:0]   o_mem_be,
   output logic [AW-1:0]     o_mem_addr,
   output logic [DW-1:0]     o_mem_wdata,
   input  logic [DW-1:0]     i_mem_rdata
);

   typedef enum logic {
      C_IDLE = 1'b0,
      C_RESP = 1'b1
   } cpu_state_t;

   cpu_state_t r_state;
   cpu_state_t w_state_nxt;
   logic [7:0] r_starve;
   logic       r_rd_pend;
   logic       r_rd_owner;

   logic w_cpu_elig;
   logic w_force_dma;
   logic w_dma_gnt;
   logic w_cpu_gnt;
   logic w_rd_issue;

   // In C_RESP the held CPU request has already been served.
   assign w_cpu_elig  = i_cpu_req & (r_state == C_IDLE);
   assign w_force_dma = i_dma_req & (r_starve == 8'(STARVE_LIMIT));
   assign w_dma_gnt   = w_force_dma | (i_dma_req & ~w_cpu_elig);
   assign w_cpu_gnt   = w_cpu_elig & ~w_force_dma;
   assign w_rd_issue  = (w_cpu_gnt & ~i_cpu_we)
                      | (w_dma_gnt & ~i_dma_we);

   assign o_dma_gnt     = w_dma_gnt;
   assign o_cpu_stalled = w_cpu_elig & ~(w_cpu_gnt & i_cpu_we);
   assign o_cpu_rvalid  = (r_state == C_RESP);
   assign o_dma_rvalid  = r_rd_pend & r_rd_owner;
   assign o_cpu_rdata   = i_mem_rdata;
   assign o_dma_rdata   = i_mem_rdata;

   // CPU response state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // CPU next state: a granted load spends exactly one cycle in C_RESP
   always_comb begin
      w_state_nxt = C_IDLE;
      unique case (r_state)
         C_IDLE: begin
            if (w_cpu_gnt && !i_cpu_we) begin
               w_state_nxt = C_RESP;
            end
         end
         C_RESP: begin
            w_state_nxt = C_IDLE;
         end
         default: begin
            w_state_nxt = C_IDLE;
         end
      endcase
   end

   // Count consecutive denied DMA cycles, saturating at the limit
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_starve <= 8'd0;
      end else if (w_dma_gnt || !i_dma_req) begin
         r_starve <= 8'd0;
      end else if (r_starve != 8'(STARVE_LIMIT)) begin
         r_starve <= r_starve + 8'd1;
      end
   end

   // Remember who owns the read returning next cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_pend  <= 1'b0;
         r_rd_owner <= 1'b0;
      end else begin
         r_rd_pend  <= w_rd_issue;
         r_rd_owner <= w_dma_gnt;
      end
   end

   // Winner drives the RAM port; idle cycles show CPU fields with we=0
   always_comb begin
      o_mem_we    = w_cpu_gnt & i_cpu_we & ~i_reset;
      o_mem_be    = i_cpu_be;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      if (w_dma_gnt) begin
         o_mem_we    = i_dma_we & ~i_reset;
         o_mem_be    = '1;
         o_mem_addr  = i_dma_addr;
         o_mem_wdata = i_dma_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter.
// Reference: transaction-level arbitration rules plus a shadow memory.
module tb_dmem_port_arbiter;

   localparam int AW  = 6;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [3:0]    cpu_be;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stalled;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic [DW-1:0] dma_rdata;
   logic          dma_rvalid;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIMIT(LIM)
   ) dut (
      .i_clk(clk),
      .i_reset(reset),
      .i_cpu_req(cpu_req),
      .i_cpu_we(cpu_we),
      .i_cpu_addr(cpu_addr),
      .i_cpu_be(cpu_be),
      .i_cpu_wdata(cpu_wdata),
      .o_cpu_stalled(cpu_stalled),
      .o_cpu_rdata(cpu_rdata),
      .o_cpu_rvalid(cpu_rvalid),
      .i_dma_req(dma_req),
      .i_dma_we(dma_we),
      .i_dma_addr(dma_addr),
      .i_dma_wdata(dma_wdata),
      .o_dma_gnt(dma_gnt),
      .o_dma_rdata(dma_rdata),
      .o_dma_rvalid(dma_rvalid),
      .o_mem_we(mem_we),
      .o_mem_be(mem_be),
      .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   // Byte-enabled RAM with registered read
   logic [DW-1:0] ram [64];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we && mem_be[b])
            ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      bit        we;
      bit [5:0]  addr;
      bit [3:0]  be;
      bit [31:0] data;
   } req_t;

   typedef struct {
      bit [31:0] data;
      int        due;
   } exp_t;

   req_t      cpu_q[$], dma_q[$];
   exp_t      cpu_exp[$], dma_exp[$];
   bit [31:0] shadow [64];
   int        checks = 0, errors = 0, cyc = 0;
   bit        cpu_act = 0, dma_act = 0, cpu_fin = 0, dma_fin = 0;
   req_t      cpu_cur, dma_cur;
   bit        resp_due = 0;
   int        dwait = 0;
   bit        hold_rst = 1, rst_on_load = 0;
   int        gap_pct = 0;
   exp_t      mon_e;

   function automatic req_t mk(bit we, int addr, bit [3:0] be,
                               bit [31:0] data);
      req_t r;
      r.we = we; r.addr = 6'(addr); r.be = be; r.data = data;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h",
                  name, cyc, act, exp);
      end
   endtask

   // One clock: release finished requests, issue new ones, then
   // predict and check this cycle's combinational outcome.
   task automatic cycle();
      bit cpu_can, dwin, cwin, stall;
      bit [31:0] m;
      @(posedge clk);
      cyc++;
      #1;
      if (cpu_fin) cpu_act = 0;
      if (dma_fin) dma_act = 0;
      cpu_fin = 0;
      dma_fin = 0;
      reset = hold_rst;
      if (!cpu_act && cpu_q.size() > 0 &&
          $urandom_range(99) >= 32'(gap_pct)) begin
         cpu_cur = cpu_q.pop_front();
         cpu_act = 1;
         if (rst_on_load && !cpu_cur.we) begin
            reset = 1;
            rst_on_load = 0;
         end
      end
      if (!dma_act && dma_q.size() > 0 &&
          $urandom_range(99) >= 32'(gap_pct)) begin
         dma_cur = dma_q.pop_front();
         dma_act = 1;
      end
      cpu_req   = cpu_act;
      cpu_we    = cpu_cur.we;
      cpu_addr  = cpu_cur.addr;
      cpu_be    = cpu_cur.be;
      cpu_wdata = cpu_cur.data;
      dma_req   = dma_act;
      dma_we    = dma_cur.we;
      dma_addr  = dma_cur.addr;
      dma_wdata = dma_cur.data;
      @(negedge clk);
      cpu_can = cpu_act && !resp_due;
      dwin    = dma_act && (dwait >= LIM || !cpu_can);
      cwin    = cpu_can && !dwin;
      stall   = cpu_can && !(cwin && cpu_cur.we);
      chk("dma_gnt", dma_gnt, dwin);
      chk("cpu_stalled", cpu_stalled, stall);
      if (reset) begin
         chk("mem_we_reset", mem_we, 0);
      end else if (dwin) begin
         chk("dma_mem_we", mem_we, dma_cur.we);
         chk("dma_mem_addr", mem_addr, dma_cur.addr);
         if (dma_cur.we) begin
            chk("dma_mem_wdata", mem_wdata, dma_cur.data);
            chk("dma_mem_be", mem_be, 4'hf);
            shadow[dma_cur.addr] = dma_cur.data;
         end else begin
            dma_exp.push_back('{shadow[dma_cur.addr], cyc + 1});
         end
      end else if (cwin) begin
         chk("cpu_mem_we", mem_we, cpu_cur.we);
         chk("cpu_mem_addr", mem_addr, cpu_cur.addr);
         if (cpu_cur.we) begin
            chk("cpu_mem_wdata", mem_wdata, cpu_cur.data);
            chk("cpu_mem_be", mem_be, cpu_cur.be);
            m = shadow[cpu_cur.addr];
            for (int b = 0; b < 4; b++)
               if (cpu_cur.be[b]) m[8*b +: 8] = cpu_cur.data[8*b +: 8];
            shadow[cpu_cur.addr] = m;
         end else begin
            cpu_exp.push_back('{shadow[cpu_cur.addr], cyc + 1});
         end
      end else begin
         chk("idle_mem_we", mem_we, 0);
      end
      if (reset) begin
         resp_due = 0;
         dwait    = 0;
      end else begin
         resp_due = cwin && !cpu_cur.we;
         if (dma_act && !dwin) dwait = (dwait < LIM) ? dwait + 1 : LIM;
         else dwait = 0;
      end
      cpu_fin = cpu_act && !stall;
      dma_fin = dwin;
   endtask

   task automatic drain(int maxc);
      int n = 0;
      while (cpu_q.size() > 0 || dma_q.size() > 0 ||
             (cpu_act && !cpu_fin) || (dma_act && !dma_fin)) begin
         if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d got=busy expected=idle", cyc);
            return;
         end
         cycle();
         n++;
      end
      cycle();
      cycle();
   endtask

   // Monitor: every read response must land exactly on its due cycle
   always @(negedge clk) begin
      if (cpu_exp.size() > 0 && cpu_exp[0].due == cyc) begin
         mon_e = cpu_exp.pop_front();
         chk("cpu_rvalid", cpu_rvalid, 1);
         chk("cpu_rdata", cpu_rdata, mon_e.data);
      end else if (cyc > 0) begin
         chk("cpu_rvalid_idle", cpu_rvalid, 0);
      end
      if (dma_exp.size() > 0 && dma_exp[0].due == cyc) begin
         mon_e = dma_exp.pop_front();
         chk("dma_rvalid", dma_rvalid, 1);
         chk("dma_rdata", dma_rdata, mon_e.data);
      end else if (cyc > 0) begin
         chk("dma_rvalid_idle", dma_rvalid, 0);
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      ram[5] = 32'hDEADBEEF;
      for (int i = 0; i < 64; i++) shadow[i] = ram[i];
      cpu_cur = mk(0, 0, 0, 0);
      dma_cur = mk(0, 0, 0, 0);
      reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0;
      cpu_wdata = '0; dma_req = 0; dma_we = 0; dma_addr = '0;
      dma_wdata = '0;
      repeat (3) cycle();
      hold_rst = 0;
      cycle();
      chk("reset_cpu_rvalid", cpu_rvalid, 0);
      chk("reset_dma_rvalid", dma_rvalid, 0);
      chk("reset_cpu_stalled", cpu_stalled, 0);

      // CPU load of a known word
      cpu_q.push_back(mk(0, 5, 4'h0, 0));
      drain(20);

      // Partial store then readback
      cpu_q.push_back(mk(1, 3, 4'b0100, 32'h00AB0000));
      cpu_q.push_back(mk(0, 3, 4'h0, 0));
      drain(20);

      // Both requesters saturating the port
      for (int i = 0; i < 20; i++) begin
         cpu_q.push_back(mk(0, $urandom_range(63), 4'h0, 0));
         dma_q.push_back(mk(0, $urandom_range(63), 4'hf, 0));
      end
      drain(200);

      // Back-to-back CPU stores against a pending DMA write
      for (int i = 0; i < 6; i++)
         cpu_q.push_back(mk(1, 10 + i, 4'hf, $urandom));
      dma_q.push_back(mk(1, 20, 4'hf, 32'h12345678));
      drain(40);

      // Reset in the cycle a CPU load is granted
      rst_on_load = 1;
      cpu_q.push_back(mk(0, 9, 4'h0, 0));
      drain(20);

      // Random mixed traffic with gaps
      gap_pct = 40;
      for (int i = 0; i < 150; i++) begin
         cpu_q.push_back(mk($urandom_range(1), $urandom_range(63),
                            4'($urandom_range(15)), $urandom));
         dma_q.push_back(mk($urandom_range(1), $urandom_range(63),
                            4'hf, $urandom));
      end
      drain(2000);
      gap_pct = 0;

      // DMA fills memory with address pattern, CPU reads it all back
      for (int a = 0; a < 64; a++) dma_q.push_back(mk(1, a, 4'hf, a));
      drain(200);
      for (int a = 0; a < 64; a++) cpu_q.push_back(mk(0, a, 4'h0, 0));
      drain(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
